// File: rtl/fix_conn_mgr.sv
// FIX session connection manager: queues app connect/disconnect requests per host,
// issues connect/disconnect commands to the TOE command FIFO, and tracks which host
// sessions are up.
// Optional feature: define FIX_CONN_RETRY_EN to re-issue a timed-out connect up to
// MAX_RETRIES times before reporting failure; otherwise the first timeout fails.
module fix_conn_mgr #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       connect_i,
  input  logic [1:0] connect_to_host_i,
  input  logic       disconnect_i,
  input  logic [1:0] disconnect_host_i,
  input  logic       connected_i,
  input  logic [1:0] connected_host_addr_i,
  output logic       connect_req_o,
  output logic [1:0] connect_addr_o,
  output logic       disconnect_o,
  output logic [1:0] disconnect_host_num_o,
  output logic [3:0] session_up_o,
  output logic       conn_fail_o,
  output logic [1:0] conn_fail_host_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDisc} state_e;

  state_e      state_q, state_d;
  logic [3:0]  pend_q, pend_d, dpend_q, dpend_d, session_q, session_d;
  logic [1:0]  sel_q, sel_d, rr_q, rr_d;
  logic [15:0] timer_q, timer_d;

  logic       req_q, req_d, disc_q, disc_d, fail_q, fail_d, busy_q, busy_d;
  logic [1:0] req_addr_q, req_addr_d, disc_num_q, disc_num_d, fail_host_q, fail_host_d;

  logic [3:0] conn_vec, disc_vec, inflight_vec;
  logic       match, abort, timeout, retry_ok;
  logic [1:0] dpick, rpick;

  // Request decode, in-flight events and host selection (lowest dpend, round-robin pend)
  always_comb begin
    conn_vec     = connect_i    ? (4'b0001 << connect_to_host_i) : 4'b0000;
    disc_vec     = disconnect_i ? (4'b0001 << disconnect_host_i) : 4'b0000;
    inflight_vec = (state_q == StReq || state_q == StWait) ? (4'b0001 << sel_q) : 4'b0000;
    match   = (state_q == StWait) && connected_i && (connected_host_addr_i == sel_q);
    abort   = (state_q == StWait) && disconnect_i && (disconnect_host_i == sel_q);
    timeout = (state_q == StWait) && (timer_q == 16'd1);
    dpick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (dpend_q[i]) dpick = 2'(i);
    end
    // Descending offset so the host right after the last-served one wins
    rpick = rr_q;
    for (int i = 4; i >= 1; i--) begin
      if (pend_q[rr_q + 2'(i)]) rpick = rr_q + 2'(i);
    end
  end

`ifdef FIX_CONN_RETRY_EN
  logic [2:0] retry_q, retry_d;

  assign retry_ok = 32'(retry_q) < MAX_RETRIES;

  // Retry count restarts on a fresh attempt and counts re-issues of the same host
  always_comb begin
    retry_d = retry_q;
    if (state_q == StIdle && state_d == StReq)      retry_d = 3'd0;
    else if (state_q == StWait && state_d == StReq) retry_d = retry_q + 3'd1;
  end

  // Retry count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retry_q <= 3'd0;
    else     retry_q <= retry_d;
  end
`else
  // Without retries the limit has no effect
  logic unused_max_retries;
  assign unused_max_retries = |MAX_RETRIES;
  assign retry_ok = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state; a disconnect of the in-flight host beats a match, a match beats a timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (|dpend_q)     state_d = StDisc;
        else if (|pend_q) state_d = StReq;
      end
      StReq:  state_d = StWait;
      StWait: begin
        if (abort || match) state_d = StIdle;
        else if (timeout)   state_d = retry_ok ? StReq : StIdle;
      end
      StDisc: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bookkeeping next state: pending vectors, sessions, selection, timer
  always_comb begin
    pend_d      = pend_q;
    dpend_d     = dpend_q;
    session_d   = session_q;
    sel_d       = sel_q;
    rr_d        = rr_q;
    timer_d     = timer_q;
    fail_d      = 1'b0;
    fail_host_d = 2'd0;
    unique case (state_q)
      StIdle: begin
        if (state_d == StDisc) begin
          sel_d            = dpick;
          dpend_d[dpick]   = 1'b0;
          session_d[dpick] = 1'b0;
        end else if (state_d == StReq) begin
          sel_d = rpick;
          rr_d  = rpick;
        end
      end
      StReq:  timer_d = 16'(TIMEOUT_CYCLES);
      StWait: begin
        timer_d = timer_q - 16'd1;
        if (abort) begin
          pend_d[sel_q] = 1'b0;
        end else if (match) begin
          session_d[sel_q] = 1'b1;
          pend_d[sel_q]    = 1'b0;
        end else if (timeout && !retry_ok) begin
          pend_d[sel_q] = 1'b0;
          fail_d        = 1'b1;
          fail_host_d   = sel_q;
        end
      end
      default: ;
    endcase
    // New requests apply after the FSM's clears; disconnect wins over connect
    pend_d  = (pend_d | (conn_vec & ~session_q & ~inflight_vec)) & ~disc_vec;
    dpend_d = dpend_d | disc_vec;
  end

  // Registered outputs decoded from the next state
  always_comb begin
    req_d      = (state_d == StReq);
    req_addr_d = req_d ? sel_d : 2'd0;
    disc_d     = (state_d == StDisc);
    disc_num_d = disc_d ? sel_d : 2'd0;
    busy_d     = (state_d != StIdle);
  end

  // Bookkeeping and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 4'd0;
      dpend_q     <= 4'd0;
      session_q   <= 4'd0;
      sel_q       <= 2'd0;
      rr_q        <= 2'd3;
      timer_q     <= 16'd0;
      req_q       <= 1'b0;
      req_addr_q  <= 2'd0;
      disc_q      <= 1'b0;
      disc_num_q  <= 2'd0;
      fail_q      <= 1'b0;
      fail_host_q <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      dpend_q     <= dpend_d;
      session_q   <= session_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      timer_q     <= timer_d;
      req_q       <= req_d;
      req_addr_q  <= req_addr_d;
      disc_q      <= disc_d;
      disc_num_q  <= disc_num_d;
      fail_q      <= fail_d;
      fail_host_q <= fail_host_d;
      busy_q      <= busy_d;
    end
  end

  assign connect_req_o         = req_q;
  assign connect_addr_o        = req_addr_q;
  assign disconnect_o          = disc_q;
  assign disconnect_host_num_o = disc_num_q;
  assign session_up_o          = session_q;
  assign conn_fail_o           = fail_q;
  assign conn_fail_host_o      = fail_host_q;
  assign busy_o                = busy_q;

endmodule

// File: tb/tb_fix_conn_mgr.sv
// Self-checking bench for fix_conn_mgr: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_fix_conn_mgr;

  localparam int unsigned Timeout    = 64;
  localparam int unsigned MaxRetries = 3;
`ifdef FIX_CONN_RETRY_EN
  localparam int Attempts = MaxRetries + 1;
`else
  localparam int Attempts = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       connect_i = 1'b0, disconnect_i = 1'b0, connected_i = 1'b0;
  logic [1:0] connect_to_host_i = 2'd0, disconnect_host_i = 2'd0, connected_host_addr_i = 2'd0;
  logic       connect_req_o, disconnect_o, conn_fail_o, busy_o;
  logic [1:0] connect_addr_o, disconnect_host_num_o, conn_fail_host_o;
  logic [3:0] session_up_o;

  always #5 clk = ~clk;

  fix_conn_mgr #(
    .TIMEOUT_CYCLES(Timeout),
    .MAX_RETRIES   (MaxRetries)
  ) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .connect_i            (connect_i),
    .connect_to_host_i    (connect_to_host_i),
    .disconnect_i         (disconnect_i),
    .disconnect_host_i    (disconnect_host_i),
    .connected_i          (connected_i),
    .connected_host_addr_i(connected_host_addr_i),
    .connect_req_o        (connect_req_o),
    .connect_addr_o       (connect_addr_o),
    .disconnect_o         (disconnect_o),
    .disconnect_host_num_o(disconnect_host_num_o),
    .session_up_o         (session_up_o),
    .conn_fail_o          (conn_fail_o),
    .conn_fail_host_o     (conn_fail_host_o),
    .busy_o               (busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sets of hosts wanting a connection / a teardown, an activity
  // (idle, issuing, waiting, tearing down) and an absolute deadline for the wait.
  localparam int PIdle = 0, PIssue = 1, PWait = 2, PDrop = 3;
  bit       want[4];
  bit       drop[4];
  bit [3:0] up;
  int       phase, cur, last, tries;
  longint   cyc = 0, deadline = 0;
  bit       e_req, e_disc, e_fail, e_busy;
  int       e_addr, e_dnum, e_fhost;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      want[i] = 1'b0;
      drop[i] = 1'b0;
    end
    up = 4'd0; phase = PIdle; cur = 0; last = 3; tries = 0;
    e_req = 0; e_disc = 0; e_fail = 0; e_busy = 0; e_addr = 0; e_dnum = 0; e_fhost = 0;
  endfunction

  // One clock edge: predicts what the outputs show during the following cycle
  function automatic void model_step(input bit c, input int ch, input bit d, input int dh,
                                     input bit k, input int kh);
    bit       old_busy_host;
    int       old_cur, h;
    bit [3:0] old_up;
    old_busy_host = (phase == PIssue || phase == PWait);
    old_cur = cur;
    old_up  = up;
    e_req = 0; e_disc = 0; e_fail = 0; e_addr = 0; e_dnum = 0; e_fhost = 0;
    case (phase)
      PIdle: begin
        h = -1;
        for (int i = 3; i >= 0; i--) if (drop[i]) h = i;
        if (h >= 0) begin
          drop[h] = 0; up[h] = 0; cur = h; phase = PDrop; e_disc = 1; e_dnum = h;
        end else begin
          for (int j = 4; j >= 1; j--) if (want[(last + j) % 4]) h = (last + j) % 4;
          if (h >= 0) begin
            last = h; cur = h; tries = 1; phase = PIssue; e_req = 1; e_addr = h;
          end
        end
      end
      PIssue: begin
        phase = PWait;
        deadline = cyc + longint'(Timeout);
      end
      PWait: begin
        if (d && dh == cur) begin
          want[cur] = 0; phase = PIdle;
        end else if (k && kh == cur) begin
          up[cur] = 1; want[cur] = 0; phase = PIdle;
        end else if (cyc == deadline) begin
          if (tries < Attempts) begin
            tries++; phase = PIssue; e_req = 1; e_addr = cur;
          end else begin
            want[cur] = 0; phase = PIdle; e_fail = 1; e_fhost = cur;
          end
        end
      end
      default: phase = PIdle;
    endcase
    if (c && !old_up[ch] && !(old_busy_host && old_cur == ch)) want[ch] = 1;
    if (d) begin
      want[dh] = 0;
      drop[dh] = 1;
    end
    e_busy = (phase != PIdle);
    cyc++;
  endfunction

  bit rst_cmd = 1'b1;
  int n_req = 0, n_disc = 0, n_fail = 0, fail_host = 0;
  int req_log[$];

  // One cycle: compare outputs mid-cycle, drive new inputs, advance the model at the edge
  task automatic step(input bit c, input int ch, input bit d, input int dh,
                      input bit k, input int kh);
    @(negedge clk);
    check_eq("connect_req_o", connect_req_o, e_req);
    check_eq("connect_addr_o", connect_addr_o, e_addr);
    check_eq("disconnect_o", disconnect_o, e_disc);
    check_eq("disconnect_host_num_o", disconnect_host_num_o, e_dnum);
    check_eq("session_up_o", session_up_o, up);
    check_eq("conn_fail_o", conn_fail_o, e_fail);
    check_eq("conn_fail_host_o", conn_fail_host_o, e_fhost);
    check_eq("busy_o", busy_o, e_busy);
    if (connect_req_o === 1'b1) begin
      n_req++;
      req_log.push_back(int'(connect_addr_o));
    end
    if (disconnect_o === 1'b1) n_disc++;
    if (conn_fail_o === 1'b1) begin
      n_fail++;
      fail_host = int'(conn_fail_host_o);
    end
    rst = rst_cmd;
    connect_i = c;    connect_to_host_i = 2'(ch);
    disconnect_i = d; disconnect_host_i = 2'(dh);
    connected_i = k;  connected_host_addr_i = 2'(kh);
    if (rst) model_reset();
    @(posedge clk);
    if (!rst) model_step(c, ch, d, dh, k, kh);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_step(input int div);
    bit c, d, k;
    int kh;
    c = ($urandom % 6) == 0;
    d = ($urandom % 25) == 0;
    if (phase == PWait && ($urandom % div) == 0) begin
      k  = 1;
      kh = (($urandom % 3) == 0) ? int'($urandom % 4) : cur;
    end else begin
      k  = ($urandom % 40) == 0;
      kh = int'($urandom % 4);
    end
    step(c, int'($urandom % 4), d, int'($urandom % 4), k, kh);
  endtask

  task automatic do_reset();
    rst_cmd = 1'b1;
    repeat (3) rand_step(4);
    rst_cmd = 1'b0;
    idle(1);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Host 0 connect answered ten cycles after the request
    n_req = 0;
    step(1, 0, 0, 0, 0, 0);
    idle(12);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    check_eq("h0_req_count", n_req, 1);
    check_eq("h0_session", session_up_o, 4'b0001);

    // Tear down host 0
    n_disc = 0;
    step(0, 0, 1, 0, 0, 0);
    idle(3);
    check_eq("h0_disc_count", n_disc, 1);
    check_eq("h0_session_down", session_up_o, 4'b0000);

    // Hosts 1 and 2 requested together after reset: round-robin serves 1 then 2
    do_reset();
    n_req = 0;
    req_log.delete();
    step(1, 1, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 60 && up != 4'b0110; i++) step(0, 0, 0, 0, phase == PWait, cur);
    idle(2);
    check_eq("rr_req_count", req_log.size(), 2);
    if (req_log.size() >= 2) begin
      check_eq("rr_first", req_log[0], 1);
      check_eq("rr_second", req_log[1], 2);
    end
    check_eq("rr_session", session_up_o, 4'b0110);

    // Host 2 never answers: retries (when enabled) then a failure pulse
    do_reset();
    n_req = 0;
    n_fail = 0;
    step(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 400 && n_fail == 0; i++) idle(1);
    idle(2);
    check_eq("timeout_req_count", n_req, Attempts);
    check_eq("timeout_fail_count", n_fail, 1);
    check_eq("timeout_fail_host", fail_host, 2);
    check_eq("timeout_session", session_up_o, 4'b0000);

    // Waiting on host 3, stray answer for host 1, then reset drops the attempt
    do_reset();
    n_fail = 0;
    step(1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 6 && phase != PWait; i++) idle(1);
    step(0, 0, 0, 0, 1, 1);
    idle(2);
    rst_cmd = 1'b1;
    repeat (3) rand_step(4);
    rst_cmd = 1'b0;
    idle(3);
    check_eq("rst_session", session_up_o, 4'b0000);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_no_fail", n_fail, 0);

    // Randomized traffic with varying TOE responsiveness, plus a mid-run reset
    for (int seg = 0; seg < 8; seg++) begin
      int div;
      case (seg % 3)
        0:       div = 1000000;
        1:       div = 40;
        default: div = 4;
      endcase
      if (seg == 5) do_reset();
      repeat (300) rand_step(div);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fix_conn_mgr.md
FIX_CONN_MGR -- requirements
Module: fix_conn_mgr

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: WAIT-state cycles before a connect attempt times out (legal 2..65535).
REQ-002 SHALL have parameter MAX_RETRIES, default 3: re-attempts after the first timeout (legal 0..7).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port connect_i  in  1  app connect request, one-cycle pulse.
REQ-006 SHALL have port connect_to_host_i  in  2  host index for connect_i.
REQ-007 SHALL have port disconnect_i  in  1  app disconnect request, one-cycle pulse.
REQ-008 SHALL have port disconnect_host_i  in  2  host index for disconnect_i.
REQ-009 SHALL have port connected_i  in  1  TOE connection-established pulse.
REQ-010 SHALL have port connected_host_addr_i  in  2  host index for connected_i.
REQ-011 SHALL have port connect_req_o  out  1  connect command to FIFO, one-cycle pulse.
REQ-012 SHALL have port connect_addr_o  out  2  host index for connect_req_o.
REQ-013 SHALL have port disconnect_o  out  1  disconnect command to FIFO, one-cycle pulse.
REQ-014 SHALL have port disconnect_host_num_o  out  2  host index for disconnect_o.
REQ-015 SHALL have port session_up_o  out  4  bit n = session to host n established.
REQ-016 SHALL have port conn_fail_o  out  1  one-cycle pulse, attempt abandoned.
REQ-017 SHALL have port conn_fail_host_o  out  2  host index for conn_fail_o.
REQ-018 SHALL have port busy_o  out  1  FSM not in IDLE.

Function
REQ-019 SHALL keep 4-bit connect-pending and 4-bit disconnect-pending vectors; connect_i sets pend[h] unless session_up_o[h] is 1 or h is in flight (then ignored).
REQ-020 SHALL set dpend[h] on disconnect_i; same-cycle connect_i and disconnect_i to one host: disconnect wins, pend[h] cleared.
REQ-021 SHALL implement FSM states IDLE, REQ, WAIT, DISC.
REQ-022 IDLE: any dpend bit -> DISC (lowest index first); else any pend bit -> select host round-robin starting after last-served host, go REQ; else stay.
REQ-023 REQ: drive connect_req_o=1, connect_addr_o=selected host for exactly one cycle, load timer with TIMEOUT_CYCLES, go WAIT.
REQ-024 WAIT: connected_i with connected_host_addr_i equal to selected host -> set session_up_o[h], clear pend[h], go IDLE; non-matching connected_i ignored.
REQ-025 WAIT: timer decrements each cycle; on reaching 0 without match -> retry or fail per REQ-033/034.
REQ-026 WAIT: disconnect_i for the in-flight host -> abandon attempt (no conn_fail_o), clear pend[h], set dpend[h], go IDLE.
REQ-027 DISC: drive disconnect_o=1, disconnect_host_num_o=h for one cycle; clear session_up_o[h] and dpend[h] same edge; go IDLE.
REQ-028 Match and timeout in the same cycle: match wins.
REQ-029 Round-robin pointer SHALL wrap 3 -> 0 and update only on REQ entry from IDLE (not on retry).
REQ-030 All outputs SHALL be registered; connect_req_o asserts 2 cycles after connect_i to an idle block.

Reset
REQ-031 On rst: state IDLE; pend, dpend, session_up_o, retry count, timer, RR pointer (=3) cleared; all outputs 0.
REQ-032 rst mid-attempt SHALL drop the attempt silently; no pulse outputs during or on release of reset.

Configuration
REQ-033 With FIX_CONN_RETRY_EN defined: timeout with retry count < MAX_RETRIES -> increment count, go REQ (re-issue same host); else conn_fail_o pulse, clear pend[h], go IDLE.
REQ-034 Without FIX_CONN_RETRY_EN: first timeout -> conn_fail_o pulse with conn_fail_host_o=h, clear pend[h], go IDLE; MAX_RETRIES unused.

Verification
REQ-035 connect_i host 0, connected_i addr 0 ten cycles after connect_req_o -> one connect_req_o with addr 0, session_up_o=4'b0001.
REQ-036 connect_i hosts 1 and 2 same window, pointer 3 -> connect_req_o addr 1 served first, then addr 2; session_up_o=4'b0110.
REQ-037 connect_i host 2, no connected_i, FIX_CONN_RETRY_EN, defaults -> 4 connect_req_o pulses 65 cycles apart, then conn_fail_o with host 2; without macro -> 1 pulse then fail.
REQ-038 Host 0 up, disconnect_i host 0 -> disconnect_o with disconnect_host_num_o=0 within 2 cycles, session_up_o=4'b0000.
REQ-039 In WAIT for host 3, connected_i addr 1 then rst asserted -> no session_up_o change, all outputs 0 after reset, no conn_fail_o.
